frame_state_latch: RTL

VGA-domain consumer of the two-flop synchronizer output for multi-bit game state. It filters the transient codes a per-bit synchronizer can produce while a multi-bit word changes, requiring the value to be stable for a set number of cycles. It then commits the qualified value only on a frame boundary, so the board renderer sees one coherent state for a whole frame. It sits between `state_sync` and the pixel/sprite renderer, clocked by `clk_vga`.

---
 rtl/chess_vga_pkg.sv | 17 +
 rtl/stable_filter.sv | 56 +++++
 rtl/frame_state_latch.sv | 79 +++++++
 3 files changed

// File: rtl/chess_vga_pkg.sv
// Shared definitions for the VGA-domain game-state path.
package chess_vga_pkg;

    // Frame latch FSM: waiting for a value to settle, settled and already
    // displayed, or settled and waiting for the next frame boundary.
    typedef enum logic [1:0] {
        FL_SETTLING = 2'd0,
        FL_STABLE   = 2'd1,
        FL_PENDING  = 2'd2
    } frame_latch_state_e;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int FL_CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stable_filter.sv
// Stability filter: tracks the most recent input word and how many
// consecutive edges it has been held. It exposes both the registered
// candidate and the next-edge view, so the frame latch can register its
// state from the same values the filter is about to store.
module stable_filter
    import chess_vga_pkg::*;
#(
    parameter int              bits          = 1,
    parameter int              STABLE_CYCLES = 4,
    parameter logic [bits-1:0] RESET_STATE   = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [bits-1:0] i_data,
    output logic [bits-1:0] o_cand,
    output logic [bits-1:0] o_cand_nxt,
    output logic            o_stable_nxt
);

    localparam int            CW = FL_CNT_W(STABLE_CYCLES);
    localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);

    logic [bits-1:0] r_cand;
    logic [bits-1:0] w_cand_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    // Any change restarts the count; an unchanged word counts up and saturates.
    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (i_data != r_cand) begin
            w_cand_nxt = i_data;
            w_cnt_nxt  = '0;
        end else if (r_cnt < SC) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // Candidate and counter registers; reset presents the reset word as
    // already qualified so nothing is considered in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cand <= RESET_STATE;
            r_cnt  <= SC;
        end else begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_cand       = r_cand;
    assign o_cand_nxt   = w_cand_nxt;
    assign o_stable_nxt = (w_cnt_nxt == SC);

endmodule

// File: rtl/frame_state_latch.sv
// Frame-coherent latch for synchronized multi-bit game state. A word must
// hold for STABLE_CYCLES edges to qualify, and a qualified word differing
// from the displayed one is only committed on a frame_start pulse.
module frame_state_latch
    import chess_vga_pkg::*;
#(
    parameter int              bits          = 1,
    parameter int              STABLE_CYCLES = 4,
    parameter logic [bits-1:0] RESET_STATE   = '0
) (
    input  logic            clk_vga,
    input  logic            rst,
    input  logic [bits-1:0] state_in,
    input  logic            frame_start,
    output logic [bits-1:0] state_frame,
    output logic            update_pulse,
    output logic            pending
);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $error("frame_state_latch: STABLE_CYCLES must be in 1..255");
    end

    frame_latch_state_e r_state;
    frame_latch_state_e w_state_nxt;
    logic [bits-1:0]    r_state_frame;
    logic [bits-1:0]    w_frame_nxt;
    logic               r_update_pulse;
    logic               w_commit;
    logic [bits-1:0]    w_cand;
    logic [bits-1:0]    w_cand_nxt;
    logic               w_stable_nxt;

    stable_filter #(
        .bits          (bits),
        .STABLE_CYCLES (STABLE_CYCLES),
        .RESET_STATE   (RESET_STATE)
    ) u_filter (
        .i_clk        (clk_vga),
        .i_rst        (rst),
        .i_data       (state_in),
        .o_cand       (w_cand),
        .o_cand_nxt   (w_cand_nxt),
        .o_stable_nxt (w_stable_nxt)
    );

    // Commit uses the registered candidate, so a word arriving on the same
    // edge as frame_start never bypasses its own qualification. The next
    // state is derived from the values all registers will hold after this edge.
    always_comb begin
        w_commit    = frame_start && (r_state == FL_PENDING);
        w_frame_nxt = w_commit ? w_cand : r_state_frame;
        if (!w_stable_nxt) begin
            w_state_nxt = FL_SETTLING;
        end else if (w_cand_nxt == w_frame_nxt) begin
            w_state_nxt = FL_STABLE;
        end else begin
            w_state_nxt = FL_PENDING;
        end
    end

    // FSM, displayed word and one-cycle update strobe.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_state        <= FL_STABLE;
            r_state_frame  <= RESET_STATE;
            r_update_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_state_frame  <= w_frame_nxt;
            r_update_pulse <= w_commit;
        end
    end

    assign state_frame  = r_state_frame;
    assign update_pulse = r_update_pulse;
    assign pending      = (r_state == FL_PENDING);

endmodule
